nv_edge_capture_bank: RTL and testbench
=======================================

NV_EDGE_CAPTURE_BANK -- requirements
Module: nv_edge_capture_bank

Interface
REQ-001 Parameter WIDTH, default 32, data bits per channel (1..64).
REQ-002 Parameter CHANNELS, default 4, number of capture channels (1..16).
REQ-003 Parameter EDGE_MODE, default 1, capture edge: 0 rising, 1 falling, 2 both.
REQ-004 One clock, nvdla_core_clk; reset nvdla_core_rstn is asynchronous and active-low; all flops on rising nvdla_core_clk.
REQ-005 nvdla_core_clk  in  1  sole clock.
REQ-006 nvdla_core_rstn  in  1  async active-low reset.
REQ-007 cap_en  in  CHANNELS  per-channel capture strobes, synchronous to clock.
REQ-008 cap_d  in  CHANNELS*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 rd_valid  out  1  output entry valid.
REQ-010 rd_ready  in  1  consumer accepts entry.
REQ-011 rd_chn  out  clog2(CHANNELS) (min 1)  source channel of entry.
REQ-012 rd_data  out  WIDTH  captured data.
REQ-013 ovf_clr  in  CHANNELS  one-cycle pulses clearing sticky overflow bits.
REQ-014 ovf_status  out  CHANNELS  sticky per-channel overflow flags.

Function
REQ-015 Edge detect per channel: compare cap_en to registered cap_en_d; rise = en & ~en_d, fall = ~en & en_d; EDGE_MODE selects.
REQ-016 On detected edge in cycle N, cap_d of that channel sampled in cycle N is written to the channel holding register; hold_full=1 from N+1.
REQ-017 Edge detection suppressed in first cycle after reset deassertion (armed flop); cap_en_d loads cap_en that cycle.
REQ-018 Edge while hold_full=1 and holding not drained same cycle: new data dropped, ovf_status bit set from next cycle.
REQ-019 Edge in same cycle holding drains to output stage: new data accepted, hold_full stays 1, no overflow.
REQ-020 Output stage: single register (rd_valid, rd_chn, rd_data), loads when empty or when rd_valid & rd_ready.
REQ-021 Load source chosen round-robin among hold_full channels, search starting at channel after last loaded; wraps CHANNELS-1 -> 0.
REQ-022 Loading clears the chosen channel's hold_full; minimum capture-to-rd_valid latency 2 cycles (edge N, rd_valid N+2).
REQ-023 While rd_valid=1 and rd_ready=0, rd_chn and rd_data hold stable.
REQ-024 rd_valid & rd_ready with no hold_full channel: rd_valid=0 next cycle; with one pending: back-to-back, rd_valid stays 1.
REQ-025 ovf_clr bit clears its ovf_status bit next cycle; simultaneous set and clear: set wins.
REQ-026 Sustained throughput one entry per cycle across channels.

Reset
REQ-027 Reset values: rd_valid=0, rd_chn=0, rd_data=0, ovf_status=0, all hold_full=0, holding data=0, cap_en_d=0, RR pointer=0, armed=0.
REQ-028 Reset assertion mid-operation discards all held and output entries immediately; no entry survives reset.

Configuration
REQ-029 Macro NV_EDGE_CAPTURE_BANK_PARITY_EN defined: holding and output registers carry one extra even-parity bit computed at capture; added port rd_par out 1 equal to XOR of rd_data as captured.
REQ-030 Macro undefined: no parity storage, no rd_par port; all other behaviour identical.

Structure
REQ-031 Package nv_edge_capture_pkg holds EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 constants and channel-index width function.
REQ-032 Sub-module nv_edge_capture_chn: one channel's edge detect, holding register, hold_full, overflow flag; instantiated CHANNELS times by generate.
REQ-033 Round-robin arbiter and output stage live in top level.

Verification
REQ-034 EDGE_MODE=1, ch0 cap_en 1->0 with cap_d=0xA5A5_0001, rd_ready=1 -> rd_valid at N+2, rd_chn=0, rd_data=0xA5A5_0001, one cycle.
REQ-035 Falling edges on ch1,ch2,ch3 same cycle, rd_ready=1 -> three consecutive entries rd_chn 1,2,3, then rd_valid=0.
REQ-036 rd_ready=0, ch0 edge twice (data 0x11 then 0x22), then third edge 0x33 -> output 0x11 stable, holding 0x22, 0x33 dropped, ovf_status[0]=1; ovf_clr[0] pulse -> 0.
REQ-037 EDGE_MODE=2, ch0 toggles 0->1->0 across cycles with data 0x5,0x6 -> two entries 0x5,0x6 in order.
REQ-038 cap_en[0]=1 held through reset release, EDGE_MODE=0 -> no capture; reset asserted with rd_valid=1 -> rd_valid=0 immediately.
REQ-039 With parity macro: capture 0x0000_0007 -> rd_par=1; 0x0000_0003 -> rd_par=0.

Source files
------------

// File: rtl/nv_edge_capture_pkg.sv
// Shared constants and helpers for the edge-capture bank.
package nv_edge_capture_pkg;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned chn_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nv_edge_capture_chn.sv
// One capture channel: edge detect, single-entry holding register, sticky overflow flag.
module nv_edge_capture_chn
    import nv_edge_capture_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned EDGE_MODE = EDGE_FALL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] d,
    input  logic          drain,
    input  logic          ovf_clr,
    output logic          hold_full,
    output logic [DW-1:0] hold_data,
    output logic          ovf
);

    logic          en_d_q;
    logic          armed_q;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] data_q, data_d;
    logic          rise, fall, det;

    assign rise = en & ~en_d_q;
    assign fall = ~en & en_d_q;

    // armed_q masks the first cycle after reset so a strobe held through reset is not an edge.
    always_comb begin
        if (EDGE_MODE == EDGE_RISE) begin
            det = armed_q & rise;
        end else if (EDGE_MODE == EDGE_FALL) begin
            det = armed_q & fall;
        end else begin
            det = armed_q & (rise | fall);
        end
    end

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ovf_d  = ovf_q & ~ovf_clr;
        if (drain) begin
            full_d = 1'b0;
        end
        if (det) begin
            if (!full_q || drain) begin
                full_d = 1'b1;
                data_d = d;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d_q  <= 1'b0;
            armed_q <= 1'b0;
            full_q  <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            en_d_q  <= en;
            armed_q <= 1'b1;
            full_q  <= full_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign hold_full = full_q;
    assign hold_data = data_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/nv_edge_capture_bank.sv
// Multi-channel edge capture with round-robin drain into a single output register.
// Optional NV_EDGE_CAPTURE_BANK_PARITY_EN adds a stored even-parity bit and the rd_par port.
module nv_edge_capture_bank
    import nv_edge_capture_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned EDGE_MODE = EDGE_FALL
) (
    input  logic                           nvdla_core_clk,
    input  logic                           nvdla_core_rstn,
    input  logic [CHANNELS-1:0]            cap_en,
    input  logic [CHANNELS*WIDTH-1:0]      cap_d,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [chn_idx_w(CHANNELS)-1:0] rd_chn,
    output logic [WIDTH-1:0]               rd_data,
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
    output logic                           rd_par,
`endif
    input  logic [CHANNELS-1:0]            ovf_clr,
    output logic [CHANNELS-1:0]            ovf_status
);

    localparam int unsigned CW = chn_idx_w(CHANNELS);
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
    localparam int unsigned DW = WIDTH + 1;
`else
    localparam int unsigned DW = WIDTH;
`endif

    logic [CHANNELS-1:0] hold_full;
    logic [CHANNELS-1:0] drain;
    logic [DW-1:0]       hold_data [CHANNELS];
    logic [CW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       sel;
    logic                found;
    logic                load;
    logic                valid_q, valid_d;
    logic [CW-1:0]       chn_q, chn_d;
    logic [DW-1:0]       data_q, data_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chn
        logic [WIDTH-1:0] d_raw;
        logic [DW-1:0]    d_store;
        assign d_raw = cap_d[i*WIDTH +: WIDTH];
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
        assign d_store = {^d_raw, d_raw};
`else
        assign d_store = d_raw;
`endif
        nv_edge_capture_chn #(
            .DW        (DW),
            .EDGE_MODE (EDGE_MODE)
        ) u_chn (
            .clk       (nvdla_core_clk),
            .rst_n     (nvdla_core_rstn),
            .en        (cap_en[i]),
            .d         (d_store),
            .drain     (drain[i]),
            .ovf_clr   (ovf_clr[i]),
            .hold_full (hold_full[i]),
            .hold_data (hold_data[i]),
            .ovf       (ovf_status[i])
        );
    end

    // ptr_q is the first channel searched; it moves to one past the last channel loaded.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            idx = (32'(ptr_q) + k) % CHANNELS;
            if (!found && hold_full[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    assign load = ~valid_q | rd_ready;

    always_comb begin
        valid_d = valid_q;
        chn_d   = chn_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        drain   = '0;
        if (load) begin
            valid_d = found;
            if (found) begin
                chn_d      = sel;
                data_d     = hold_data[sel];
                ptr_d      = CW'((32'(sel) + 1) % CHANNELS);
                drain[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            valid_q <= 1'b0;
            chn_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            chn_q   <= chn_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_chn   = chn_q;
    assign rd_data  = data_q[WIDTH-1:0];
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
    assign rd_par   = data_q[WIDTH];
`endif

endmodule

// File: tb/tb_nv_edge_capture_bank.sv
// Bench for nv_edge_capture_bank: directed table, hand sequences for other edge modes, random vs model.
module tb_nv_edge_capture_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, rstn_r;

    // Main DUT: falling-edge capture, modelled cycle by cycle.
    logic [3:0]   cap_en, ovf_clr, ovf_status;
    logic [127:0] cap_d;
    logic         rd_ready, rd_valid, rd_par;
    logic [1:0]   rd_chn;
    logic [31:0]  rd_data;

    // Both-edge DUT.
    logic [3:0]   cap_en_b, ovf_clr_b, ovf_status_b;
    logic [127:0] cap_d_b;
    logic         rd_ready_b, rd_valid_b, rd_par_b;
    logic [1:0]   rd_chn_b;
    logic [31:0]  rd_data_b;

    // Rising-edge DUT with its own reset.
    logic [3:0]   cap_en_r, ovf_clr_r, ovf_status_r;
    logic [127:0] cap_d_r;
    logic         rd_ready_r, rd_valid_r, rd_par_r;
    logic [1:0]   rd_chn_r;
    logic [31:0]  rd_data_r;

    nv_edge_capture_bank #(.WIDTH(32), .CHANNELS(4), .EDGE_MODE(1)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cap_en          (cap_en),
        .cap_d           (cap_d),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_chn          (rd_chn),
        .rd_data         (rd_data),
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
        .rd_par          (rd_par),
`endif
        .ovf_clr         (ovf_clr),
        .ovf_status      (ovf_status)
    );

    nv_edge_capture_bank #(.WIDTH(32), .CHANNELS(4), .EDGE_MODE(2)) dut_b (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cap_en          (cap_en_b),
        .cap_d           (cap_d_b),
        .rd_valid        (rd_valid_b),
        .rd_ready        (rd_ready_b),
        .rd_chn          (rd_chn_b),
        .rd_data         (rd_data_b),
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
        .rd_par          (rd_par_b),
`endif
        .ovf_clr         (ovf_clr_b),
        .ovf_status      (ovf_status_b)
    );

    nv_edge_capture_bank #(.WIDTH(32), .CHANNELS(4), .EDGE_MODE(0)) dut_r (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn_r),
        .cap_en          (cap_en_r),
        .cap_d           (cap_d_r),
        .rd_valid        (rd_valid_r),
        .rd_ready        (rd_ready_r),
        .rd_chn          (rd_chn_r),
        .rd_data         (rd_data_r),
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
        .rd_par          (rd_par_r),
`endif
        .ovf_clr         (ovf_clr_r),
        .ovf_status      (ovf_status_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the main DUT: per-channel one-deep holding slot, one output slot.
    bit          m_valid;
    int          m_chn;
    logic [31:0] m_data;
    int          m_ptr;
    bit          m_armed;
    bit   [3:0]  m_prev, m_full, m_ovf;
    logic [31:0] m_hold [4];

    task automatic model_reset();
        m_valid = 0; m_chn = 0; m_data = '0; m_ptr = 0; m_armed = 0;
        m_prev = '0; m_full = '0; m_ovf = '0;
        for (int c = 0; c < 4; c++) m_hold[c] = '0;
    endtask

    task automatic model_step();
        bit       fire, edge_c;
        int       pick, idx;
        bit [3:0] nfull, novf;
        fire = !m_valid || rd_ready;
        pick = -1;
        if (fire) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (pick < 0 && m_full[idx]) pick = idx;
            end
            if (pick >= 0) begin
                m_valid = 1; m_chn = pick; m_data = m_hold[pick]; m_ptr = (pick + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            edge_c   = m_armed && m_prev[c] && !cap_en[c];
            nfull[c] = (pick == c) ? 1'b0 : m_full[c];
            novf[c]  = m_ovf[c] && !ovf_clr[c];
            if (edge_c) begin
                if (!m_full[c] || pick == c) begin
                    nfull[c] = 1'b1;
                    m_hold[c] = cap_d[c*32 +: 32];
                end else begin
                    novf[c] = 1'b1;
                end
            end
        end
        m_full = nfull; m_ovf = novf; m_prev = cap_en; m_armed = 1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model();
        chk("model_valid", rd_valid, m_valid);
        if (m_valid) begin
            chk("model_chn", rd_chn, m_chn);
            chk("model_data", rd_data, m_data);
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
            chk("model_par", rd_par, ^m_data);
`endif
        end
        chk("model_ovf", ovf_status, m_ovf);
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  clr;
        logic        ev;
        logic [1:0]  ec;
        logic [31:0] ed;
        logic [3:0]  eo;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl[0]  = '{4'h1, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[1]  = '{4'h0, 32'hA5A5_0001, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[2]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b1, 2'd0, 32'hA5A5_0001, 4'h0};
        tbl[3]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[4]  = '{4'hE, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[5]  = '{4'h0, 32'h100,       1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[6]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b1, 2'd1, 32'h100,       4'h0};
        tbl[7]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b1, 2'd2, 32'h100,       4'h0};
        tbl[8]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b1, 2'd3, 32'h100,       4'h0};
        tbl[9]  = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[10] = '{4'h1, 32'h0,         1'b0, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[11] = '{4'h0, 32'h11,        1'b0, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[12] = '{4'h1, 32'h0,         1'b0, 4'h0, 1'b1, 2'd0, 32'h11,        4'h0};
        tbl[13] = '{4'h0, 32'h22,        1'b0, 4'h0, 1'b1, 2'd0, 32'h11,        4'h0};
        tbl[14] = '{4'h1, 32'h0,         1'b0, 4'h0, 1'b1, 2'd0, 32'h11,        4'h0};
        tbl[15] = '{4'h0, 32'h33,        1'b0, 4'h0, 1'b1, 2'd0, 32'h11,        4'h1};
        tbl[16] = '{4'h0, 32'h0,         1'b0, 4'h1, 1'b1, 2'd0, 32'h11,        4'h0};
        tbl[17] = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b1, 2'd0, 32'h22,        4'h0};
        tbl[18] = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};
        tbl[19] = '{4'h0, 32'h0,         1'b1, 4'h0, 1'b0, 2'd0, 32'h0,         4'h0};

        rstn = 1'b0; rstn_r = 1'b0;
        cap_en = '0; cap_d = '0; rd_ready = 1'b1; ovf_clr = '0;
        cap_en_b = '0; cap_d_b = '0; rd_ready_b = 1'b1; ovf_clr_b = '0;
        cap_en_r = 4'h1; cap_d_r = '0; rd_ready_r = 1'b0; ovf_clr_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rd_valid, 0);
        chk("reset_chn", rd_chn, 0);
        chk("reset_data", rd_data, 0);
        chk("reset_ovf", ovf_status, 0);
        rstn = 1'b1; rstn_r = 1'b1;
        step(); step();

        for (int i = 0; i < 20; i++) begin
            cap_en = tbl[i].en; cap_d = {4{tbl[i].d}}; rd_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_chn", i), rd_chn, tbl[i].ec);
                chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].ed);
`ifdef NV_EDGE_CAPTURE_BANK_PARITY_EN
                chk($sformatf("tbl%0d_par", i), rd_par, ^tbl[i].ed);
`endif
            end
            chk($sformatf("tbl%0d_ovf", i), ovf_status, tbl[i].eo);
        end

        // Rising mode: strobe held high through reset release must not capture.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rise_held_no_cap", rd_valid_r, 0);
        end
        cap_en_r = 4'h0; step();
        cap_en_r = 4'h1; cap_d_r[31:0] = 32'h77; step();
        step();
        chk("rise_cap_valid", rd_valid_r, 1);
        chk("rise_cap_data", rd_data_r, 32'h77);
        #3 rstn_r = 1'b0;
        #1;
        chk("rise_async_rst_valid", rd_valid_r, 0);
        chk("rise_async_rst_data", rd_data_r, 0);
        @(posedge clk); #1;
        rstn_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rise_after_rst_no_cap", rd_valid_r, 0);
        end

        // Both-edge mode: 0->1 then 1->0 on consecutive cycles gives two ordered entries.
        cap_en_b = 4'h1; cap_d_b[31:0] = 32'h5; step();
        cap_en_b = 4'h0; cap_d_b[31:0] = 32'h6; step();
        chk("both_first_valid", rd_valid_b, 1);
        chk("both_first_data", rd_data_b, 32'h5);
        step();
        chk("both_second_valid", rd_valid_b, 1);
        chk("both_second_data", rd_data_b, 32'h6);
        step();
        chk("both_drained", rd_valid_b, 0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                rstn = 1'b0;
                model_reset();
                #1;
                chk("rand_rst_valid", rd_valid, 0);
                chk("rand_rst_ovf", ovf_status, 0);
                @(posedge clk); #1;
                rstn = 1'b1;
            end
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 2) == 0) cap_en[c] = ~cap_en[c];
                cap_d[c*32 +: 32] = $urandom;
                ovf_clr[c] = ($urandom_range(0, 7) == 0);
            end
            rd_ready = ($urandom_range(0, 3) != 0);
            step();
            compare_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
